// File: rtl/ambi_led_pkg.sv
// Shared constants and helpers for the ambient-light WS2812 strip transmitters.
// Timing values assume a 148.5 MHz pixel clock.
package ambi_led_pkg;
    localparam int WS_TBIT    = 186;
    localparam int WS_T0H     = 59;
    localparam int WS_T1H     = 119;
    localparam int WS_TRST    = 41580;
    localparam int WS_CNT_W   = 16;
    localparam int NUM_LED_UP = 78;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BIT  = 2'd1,
        S_RST  = 2'd2
    } led_state_e;

    // The strip expects green first; the zone words arrive as {R,G,B}.
    function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction
endpackage

// File: rtl/ws2812_bit_timer.sv
// One WS2812 bit slot: counts 0..TBIT-1 and drives the registered data line high
// for T0H or T1H cycles depending on the bit being sent.
module ws2812_bit_timer #(
    parameter int TBIT  = 186,
    parameter int T0H   = 59,
    parameter int T1H   = 119,
    parameter int CNT_W = 16
) (
    input  logic clkn,
    input  logic reset,
    input  logic start,
    input  logic run,
    input  logic en_nxt,
    input  logic bit_nxt,
    output logic dout,
    output logic bit_end
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;

    // dout is computed from the next count so the registered line lines up with cnt_q.
    always_comb begin
        bit_end = run && (cnt_q == CNT_W'(TBIT - 1));
        cnt_d   = cnt_q;
        if (start || bit_end) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
        dout_d = en_nxt && (cnt_d < (bit_nxt ? CNT_W'(T1H) : CNT_W'(T0H)));
    end

    always_ff @(negedge clkn or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
endmodule

// File: rtl/ws2812_tx_up.sv
// Top-edge strip transmitter: buffers one frame of NUM_LED zone words, then
// serialises them GRB/MSB-first onto the WS2812 line and holds the latch gap.
module ws2812_tx_up
    import ambi_led_pkg::*;
#(
    parameter int NUM_LED = NUM_LED_UP,
    parameter int TBIT    = WS_TBIT,
    parameter int T0H     = WS_T0H,
    parameter int T1H     = WS_T1H,
    parameter int TRST    = WS_TRST,
    parameter int CNT_W   = WS_CNT_W
) (
    input  logic        clkn,
    input  logic        reset,
    input  logic        dv_RGB_in,
    input  logic [23:0] RGB_in,
    output logic        led_dout,
    output logic        busy,
    output logic        frame_done,
    output logic        drop
);
    localparam int IDX_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

    if (!(NUM_LED > 0 && T0H > 0 && T0H < T1H && T1H < TBIT && TRST > 0 &&
          TRST < (1 << CNT_W) && TBIT <= (1 << CNT_W))) begin : g_bad_params
        $error("ws2812_tx_up: illegal timing parameters");
    end

    led_state_e       state_q, state_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] led_idx_q, led_idx_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic [23:0]      sh_q, sh_d;
    logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             drop_q, drop_d;
    logic [23:0]      mem_q [NUM_LED];
    logic             mem_we, launch, bit_end;
    logic [IDX_W-1:0] rd_idx;
    logic [23:0]      word0;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        led_idx_d = led_idx_q;
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        rst_cnt_d = rst_cnt_q;
        drop_d    = 1'b0;
        mem_we    = 1'b0;
        launch    = 1'b0;
        rd_idx    = (led_idx_q == IDX_W'(NUM_LED - 1)) ? '0 : led_idx_q + 1'b1;
        // Bypass so a single-LED frame launches with the word being captured.
        word0     = (wr_ptr_q == '0) ? RGB_in : mem_q[0];
        case (state_q)
            S_IDLE: begin
                if (dv_RGB_in) begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == IDX_W'(NUM_LED - 1)) begin
                        launch    = 1'b1;
                        state_d   = S_BIT;
                        wr_ptr_d  = '0;
                        led_idx_d = '0;
                        bit_idx_d = '0;
                        sh_d      = rgb_to_grb(word0);
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end else if (wr_ptr_q != '0) begin
                    wr_ptr_d = '0;
                    drop_d   = 1'b1;
                end
            end
            S_BIT: begin
                drop_d = dv_RGB_in;
                if (bit_end) begin
                    if (bit_idx_q < 5'd23) begin
                        sh_d      = {sh_q[22:0], 1'b0};
                        bit_idx_d = bit_idx_q + 1'b1;
                    end else if (led_idx_q < IDX_W'(NUM_LED - 1)) begin
                        sh_d      = rgb_to_grb(mem_q[rd_idx]);
                        bit_idx_d = '0;
                        led_idx_d = rd_idx;
                    end else begin
                        state_d   = S_RST;
                        rst_cnt_d = '0;
                    end
                end
            end
            S_RST: begin
                drop_d = dv_RGB_in;
                if (rst_cnt_q == CNT_W'(TRST - 1)) begin
                    state_d   = S_IDLE;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge clkn or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            led_idx_q <= '0;
            bit_idx_q <= '0;
            sh_q      <= '0;
            rst_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            led_idx_q <= led_idx_d;
            bit_idx_q <= bit_idx_d;
            sh_q      <= sh_d;
            rst_cnt_q <= rst_cnt_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(negedge clkn) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= RGB_in;
        end
    end

    ws2812_bit_timer #(
        .TBIT (TBIT),
        .T0H  (T0H),
        .T1H  (T1H),
        .CNT_W(CNT_W)
    ) u_timer (
        .clkn   (clkn),
        .reset  (reset),
        .start  (launch),
        .run    (state_q == S_BIT),
        .en_nxt (state_d == S_BIT),
        .bit_nxt(sh_d[23]),
        .dout   (led_dout),
        .bit_end(bit_end)
    );

    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_RST) && (rst_cnt_q == CNT_W'(TRST - 1));
    assign drop       = drop_q;
endmodule

// File: tb/tb_ws2812_tx_up.sv
// Randomised scoreboard bench for ws2812_tx_up with shortened strip timing.
module tb_ws2812_tx_up;
    localparam int NL    = 4;
    localparam int TB    = 10;
    localparam int T0    = 3;
    localparam int T1    = 7;
    localparam int TR    = 50;
    localparam int BITS  = NL * 24 * TB;
    localparam int FRAME = BITS + TR;

    typedef logic [23:0] frame_t [NL];

    logic        clkn = 1'b1;
    logic        reset = 1'b1;
    logic        dv = 1'b0;
    logic [23:0] rgb = '0;
    logic        led_dout, busy, frame_done, drop;

    ws2812_tx_up #(
        .NUM_LED(NL), .TBIT(TB), .T0H(T0), .T1H(T1), .TRST(TR), .CNT_W(16)
    ) dut (
        .clkn      (clkn),
        .reset     (reset),
        .dv_RGB_in (dv),
        .RGB_in    (rgb),
        .led_dout  (led_dout),
        .busy      (busy),
        .frame_done(frame_done),
        .drop      (drop)
    );

    always #5 clkn = ~clkn;

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] exp_q [$];
    int          m_rem = 0;
    int          m_wr  = 0;
    frame_t      m_words;
    frame_t      m_cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] grb(input logic [23:0] c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

    // Expected line level from the offset into the frame.
    function automatic logic dout_model(input int rem);
        int o, b, ph;
        logic [23:0] w;
        logic v;
        if (rem == 0) return 1'b0;
        o = FRAME - rem;
        if (o >= BITS) return 1'b0;
        b  = o / TB;
        ph = o % TB;
        w  = m_cur[b / 24];
        v  = w[23 - (b % 24)];
        return (ph < (v ? T1 : T0));
    endfunction

    // Reference model: acceptance, busy window, drops and line level each cycle.
    initial begin
        bit bk, e_drop;
        forever begin
            @(posedge clkn);
            if (reset) begin
                m_rem = 0;
                m_wr  = 0;
                chk("rst_busy", busy, 0);
                chk("rst_frame_done", frame_done, 0);
                chk("rst_drop", drop, 0);
                chk("rst_dout", led_dout, 0);
            end else begin
                bk     = (m_rem > 0);
                e_drop = 1'b0;
                if (bk) begin
                    e_drop = dv;
                    m_rem--;
                end else if (dv) begin
                    m_words[m_wr] = grb(rgb);
                    m_wr++;
                    if (m_wr == NL) begin
                        for (int i = 0; i < NL; i++) exp_q.push_back(m_words[i]);
                        m_cur = m_words;
                        m_rem = FRAME;
                        m_wr  = 0;
                    end
                end else if (m_wr > 0) begin
                    m_wr   = 0;
                    e_drop = 1'b1;
                end
                chk("busy", busy, (m_rem > 0));
                chk("frame_done", frame_done, (m_rem == 1));
                chk("drop", drop, e_drop);
                chk("led_dout", led_dout, dout_model(m_rem));
            end
        end
    end

    // Line decoder: pulse width -> bit, period check, frame words vs scoreboard.
    initial begin
        logic        prev;
        int          hi, since, nbits;
        logic [95:0] acc;
        prev = 0; hi = 0; since = 0; nbits = 0; acc = '0;
        forever begin
            @(posedge clkn);
            if (reset) begin
                prev = 0; hi = 0; since = 0; nbits = 0;
            end else begin
                if (led_dout && !prev) begin
                    if (nbits > 0) chk("bit_period", since, TB);
                    since = 0;
                    hi    = 0;
                end
                if (led_dout) hi++;
                if (!led_dout && prev) begin
                    if (hi != T0 && hi != T1) chk("high_width", hi, T0);
                    acc = {acc[94:0], (hi == T1)};
                    nbits++;
                    if (nbits == NL * 24) begin
                        for (int i = 0; i < NL; i++) begin
                            if (exp_q.size() == 0) chk("frame_unexpected", 1, 0);
                            else chk("frame_word", acc[95 - 24*i -: 24], exp_q.pop_front());
                        end
                        nbits = 0;
                    end
                end
                since++;
                prev = led_dout;
            end
        end
    end

    task automatic tick();
        @(posedge clkn);
        #1;
    endtask

    task automatic send(input logic [23:0] w);
        tick();
        dv  = 1'b1;
        rgb = w;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            dv = 1'b0;
        end
    endtask

    task automatic send_frame(input frame_t f);
        for (int i = 0; i < NL; i++) send(f[i]);
        idle(1);
    endtask

    task automatic rand_frame(output frame_t f);
        for (int i = 0; i < NL; i++) f[i] = 24'($urandom);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < FRAME + 200; k++) begin
            tick();
            if (m_rem == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("wait_idle_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        bit ok;
        repeat (3) tick();
        reset = 1'b0;
        idle(3);

        f = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hA5A5A5};
        send_frame(f);
        wait_idle();
        idle(5);

        f = '{24'h0, 24'h0, 24'h0, 24'h0};
        send_frame(f);
        wait_idle();
        idle(5);

        // Short frame, then a normal one.
        send(24'($urandom));
        send(24'($urandom));
        idle(10);
        rand_frame(f);
        send_frame(f);
        wait_idle();
        idle(3);

        // Words while busy are dropped; the next frame is accepted.
        rand_frame(f);
        send_frame(f);
        idle(100);
        for (int i = 0; i < NL; i++) send(24'($urandom));
        idle(1);
        wait_idle();
        idle(2);
        rand_frame(f);
        send_frame(f);

        // Word in the frame_done cycle is dropped, next frame starts right after.
        ok = 1'b0;
        for (int k = 0; k < FRAME + 200; k++) begin
            tick();
            if (m_rem == 1) begin ok = 1'b1; break; end
        end
        if (!ok) chk("frame_done_timeout", 0, 1);
        dv  = 1'b1;
        rgb = 24'($urandom);
        rand_frame(f);
        send_frame(f);
        wait_idle();

        repeat (4) begin
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, NL - 1)) send(24'($urandom));
                idle($urandom_range(1, 4));
            end
            idle($urandom_range(0, 5));
            rand_frame(f);
            send_frame(f);
            wait_idle();
        end

        // Asynchronous reset in the middle of the bit stream.
        rand_frame(f);
        send_frame(f);
        idle(300);
        @(posedge clkn);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_dout", led_dout, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_frame_done", frame_done, 0);
        chk("async_rst_drop", drop, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        idle(3);
        rand_frame(f);
        send_frame(f);
        wait_idle();
        idle(5);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
